// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the gpio peripheral.
//   slave  : arbiter view (takes requests and peripheral read data, drives grants,
//            responses and peripheral strobes)
//   master : environment view (requesters plus gpio peripheral)
interface gpio_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned GPIO_W = 4
);
    logic              req0_i;
    logic              req1_i;
    logic              we0_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [31:0]       wdata0_i;
    logic [31:0]       wdata1_i;
    logic              gnt0_o;
    logic              gnt1_o;
    logic              rvalid0_o;
    logic              rvalid1_o;
    logic [31:0]       rdata0_o;
    logic [31:0]       rdata1_o;
    logic              err0_o;
    logic              err1_o;
    logic              gpio_valid_o;
    logic              gpio_we_o;
    logic              gpio_sel_led_o;
    logic              gpio_sel_but_o;
    logic [GPIO_W-1:0] gpio_data_m_o;
    logic [GPIO_W-1:0] gpio_data_s_i;

    modport slave (
        input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
        input  gpio_data_s_i,
        output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o, err0_o, err1_o,
        output gpio_valid_o, gpio_we_o, gpio_sel_led_o, gpio_sel_but_o, gpio_data_m_o
    );

    modport master (
        output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
        output gpio_data_s_i,
        input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o, err0_o, err1_o,
        input  gpio_valid_o, gpio_we_o, gpio_sel_led_o, gpio_sel_but_o, gpio_data_m_o
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Two-port round-robin arbiter sequencing accesses onto the single-ported gpio block.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous reset, active-high
//   bus    - gpio_bus_arbiter_if.slave: requester 0/1 req/we/addr/wdata in,
//            gnt (combinational, IDLE only) / rvalid / rdata / err out,
//            gpio valid/we/sel_led/sel_but/data_m out, gpio data_s in.
// Everything except the grants is driven from registers.
module gpio_bus_arbiter #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = ADDR_W'(32'h0002_0000),
    parameter int unsigned         GPIO_W    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    gpio_bus_arbiter_if.slave      bus
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                gpio_valid_q, gpio_valid_d;
    logic                gpio_we_q, gpio_we_d;
    logic                sel_led_q, sel_led_d;
    logic                sel_but_q, sel_but_d;
    logic [GPIO_W-1:0]   data_m_q, data_m_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                gnt0_c, gnt1_c;
    logic                pick1_c;
    logic                win_we_c;
    logic [ADDR_W-1:0]   win_addr_c;
    logic [GPIO_W-1:0]   win_wdata_c;
    logic                mapped_c;
    logic                sel_but_c;
    logic [DATA_W-1:0]   capture_c;

    // Byte offset and the upper write-data bits never reach the peripheral.
    logic unused_bits;
    assign unused_bits = ^{bus.addr0_i[1:0], bus.addr1_i[1:0],
                           bus.wdata0_i[DATA_W-1:GPIO_W], bus.wdata1_i[DATA_W-1:GPIO_W]};

    // Port 1 wins when alone, or on contention when port 0 was granted last.
    assign pick1_c     = bus.req1_i & (~bus.req0_i | ~last_grant_q);
    assign win_we_c    = pick1_c ? bus.we1_i   : bus.we0_i;
    assign win_addr_c  = pick1_c ? bus.addr1_i : bus.addr0_i;
    assign win_wdata_c = pick1_c ? bus.wdata1_i[GPIO_W-1:0] : bus.wdata0_i[GPIO_W-1:0];

    // Mapped window: word 0 = LED, word 1 = button; words 2/3 and anything outside are unmapped.
    assign mapped_c  = (win_addr_c[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]) && !win_addr_c[3];
    assign sel_but_c = win_addr_c[2];

    // Writes answer with zero data; reads return the zero-extended peripheral value.
    assign capture_c = we_q ? '0 : DATA_W'(bus.gpio_data_s_i);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;
        gpio_valid_d = 1'b0;
        gpio_we_d    = 1'b0;
        sel_led_d    = 1'b0;
        sel_but_d    = 1'b0;
        data_m_d     = data_m_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = '0;
        rdata1_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if ((bus.req0_i || bus.req1_i) && !rst_i) begin
                    gnt0_c       = !pick1_c;
                    gnt1_c       = pick1_c;
                    last_grant_d = pick1_c;
                    port_d       = pick1_c;
                    we_d         = win_we_c;
                    if (mapped_c) begin
                        state_d      = ST_ISSUE;
                        gpio_valid_d = 1'b1;
                        gpio_we_d    = win_we_c;
                        sel_led_d    = !sel_but_c;
                        sel_but_d    = sel_but_c;
                        data_m_d     = win_wdata_c;
                    end else begin
                        // Unmapped: skip the peripheral and answer with an error next cycle.
                        state_d   = ST_RESP;
                        rvalid0_d = !pick1_c;
                        rvalid1_d = pick1_c;
                        err0_d    = !pick1_c;
                        err1_d    = pick1_c;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d   = ST_RESP;
                rvalid0_d = !port_q;
                rvalid1_d = port_q;
                if (port_q) begin
                    rdata1_d = capture_c;
                end else begin
                    rdata0_d = capture_c;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            gpio_valid_q <= 1'b0;
            gpio_we_q    <= 1'b0;
            sel_led_q    <= 1'b0;
            sel_but_q    <= 1'b0;
            data_m_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            gpio_valid_q <= gpio_valid_d;
            gpio_we_q    <= gpio_we_d;
            sel_led_q    <= sel_led_d;
            sel_but_q    <= sel_but_d;
            data_m_q     <= data_m_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign bus.gnt0_o         = gnt0_c;
    assign bus.gnt1_o         = gnt1_c;
    assign bus.rvalid0_o      = rvalid0_q;
    assign bus.rvalid1_o      = rvalid1_q;
    assign bus.rdata0_o       = rdata0_q;
    assign bus.rdata1_o       = rdata1_q;
    assign bus.err0_o         = err0_q;
    assign bus.err1_o         = err1_q;
    assign bus.gpio_valid_o   = gpio_valid_q;
    assign bus.gpio_we_o      = gpio_we_q;
    assign bus.gpio_sel_led_o = sel_led_q;
    assign bus.gpio_sel_but_o = sel_but_q;
    assign bus.gpio_data_m_o  = data_m_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Testbench for gpio_bus_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level timing model.
module tb_gpio_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned GPIO_W = 4;
    localparam logic [31:0] BASE   = 32'h0002_0000;
    localparam int          MAXC   = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gpio_bus_arbiter_if #(.ADDR_W(ADDR_W), .GPIO_W(GPIO_W)) bus ();

    gpio_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .GPIO_W   (GPIO_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Requester state: a request is held until the model says it was granted.
    logic        p_req   [2];
    logic        p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    bit          rearm;
    bit          rst_drv;
    bit          gfix_en;
    logic [3:0]  gfix_val;

    // Model: per-cycle expected events, scheduled when a grant is predicted.
    int          cyc;
    int          free_at;
    int          last_grant;
    logic [3:0]  exp_dm;
    bit          ev_valid [MAXC];
    bit          ev_we    [MAXC];
    bit          ev_but   [MAXC];
    logic [3:0]  ev_dm    [MAXC];
    int          ev_rv    [MAXC];   // 0 none, 1 port 0, 2 port 1
    bit          ev_rd    [MAXC];
    bit          ev_err   [MAXC];
    logic [3:0]  ghist    [MAXC];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        p_req[p]   = 1'b1;
        p_we[p]    = we;
        p_addr[p]  = addr;
        p_wdata[p] = wdata;
    endtask

    // One clock cycle: drive, predict, compare, advance.
    task automatic step();
        int          w;
        bit          g;
        bit          mapped;
        logic [3:0]  gd;
        logic [31:0] rd;

        gd = gfix_en ? gfix_val : 4'($urandom);
        ghist[cyc] = gd;
        rst               = rst_drv;
        bus.req0_i        = p_req[0];
        bus.we0_i         = p_we[0];
        bus.addr0_i       = p_addr[0];
        bus.wdata0_i      = p_wdata[0];
        bus.req1_i        = p_req[1];
        bus.we1_i         = p_we[1];
        bus.addr1_i       = p_addr[1];
        bus.wdata1_i      = p_wdata[1];
        bus.gpio_data_s_i = gd;

        @(negedge clk);

        if (ev_valid[cyc]) exp_dm = ev_dm[cyc];

        g = 1'b0;
        w = 0;
        if (!rst_drv && cyc >= free_at && (p_req[0] || p_req[1])) begin
            g = 1'b1;
            if (p_req[0] && p_req[1]) w = 1 - last_grant;
            else                      w = p_req[1] ? 1 : 0;
            last_grant = w;
            mapped = (p_addr[w] >= BASE) && (p_addr[w] < BASE + 32'd8);
            if (mapped) begin
                ev_valid[cyc+1] = 1'b1;
                ev_we[cyc+1]    = p_we[w];
                ev_but[cyc+1]   = (p_addr[w] >= BASE + 32'd4);
                ev_dm[cyc+1]    = p_wdata[w][3:0];
                ev_rv[cyc+3]    = w + 1;
                ev_rd[cyc+3]    = !p_we[w];
                ev_err[cyc+3]   = 1'b0;
                free_at         = cyc + 4;
            end else begin
                ev_rv[cyc+1]    = w + 1;
                ev_rd[cyc+1]    = 1'b0;
                ev_err[cyc+1]   = 1'b1;
                free_at         = cyc + 2;
            end
        end

        rd = (ev_rv[cyc] != 0 && ev_rd[cyc] && cyc > 0) ? {28'h0, ghist[cyc-1]} : 32'h0;

        chk1 ("gnt0",     bus.gnt0_o,         g && w == 0);
        chk1 ("gnt1",     bus.gnt1_o,         g && w == 1);
        chk1 ("gpio_valid", bus.gpio_valid_o, ev_valid[cyc]);
        chk1 ("gpio_we",  bus.gpio_we_o,      ev_valid[cyc] && ev_we[cyc]);
        chk1 ("sel_led",  bus.gpio_sel_led_o, ev_valid[cyc] && !ev_but[cyc]);
        chk1 ("sel_but",  bus.gpio_sel_but_o, ev_valid[cyc] && ev_but[cyc]);
        chk32("data_m",   32'(bus.gpio_data_m_o), 32'(exp_dm));
        chk1 ("rvalid0",  bus.rvalid0_o,      ev_rv[cyc] == 1);
        chk1 ("rvalid1",  bus.rvalid1_o,      ev_rv[cyc] == 2);
        chk32("rdata0",   bus.rdata0_o,       (ev_rv[cyc] == 1) ? rd : 32'h0);
        chk32("rdata1",   bus.rdata1_o,       (ev_rv[cyc] == 2) ? rd : 32'h0);
        chk1 ("err0",     bus.err0_o,         ev_rv[cyc] == 1 && ev_err[cyc]);
        chk1 ("err1",     bus.err1_o,         ev_rv[cyc] == 2 && ev_err[cyc]);

        if (g && !rearm) p_req[w] = 1'b0;

        // Reset drops whatever is in flight from the next cycle onwards.
        if (rst_drv) begin
            for (int k = 1; k <= 4; k++) begin
                ev_valid[cyc+k] = 1'b0;
                ev_rv[cyc+k]    = 0;
                ev_rd[cyc+k]    = 1'b0;
                ev_err[cyc+k]   = 1'b0;
            end
            free_at    = cyc + 1;
            last_grant = 1;
            exp_dm     = 4'h0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0: a = BASE + 32'($urandom_range(0, 3));
            1: a = BASE + 32'd4 + 32'($urandom_range(0, 3));
            2: a = BASE + 32'd8 + 32'($urandom_range(0, 7));
            3: a = BASE + 32'd16 + 32'($urandom_range(0, 255));
            4: a = $urandom;
            default: a = BASE ^ (32'h1 << $urandom_range(4, 31));
        endcase
        set_req(p, 1'($urandom), a, $urandom);
    endtask

    initial begin
        cyc = 0; free_at = 0; last_grant = 1; exp_dm = 4'h0;
        rearm = 1'b0; gfix_en = 1'b0; gfix_val = 4'h0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 32'h0; p_wdata[p] = 32'h0;
        end
        rst = 1'b1;
        bus.req0_i = 1'b0; bus.req1_i = 1'b0; bus.we0_i = 1'b0; bus.we1_i = 1'b0;
        bus.addr0_i = '0; bus.addr1_i = '0; bus.wdata0_i = '0; bus.wdata1_i = '0;
        bus.gpio_data_s_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;

        // Port 0 write to the LED register.
        set_req(0, 1'b1, BASE, 32'h0000_000A);
        repeat (5) step();

        // Port 1 read of the button register with a fixed peripheral value.
        gfix_en = 1'b1; gfix_val = 4'h5;
        set_req(1, 1'b0, BASE + 32'd4, 32'hDEAD_BEEF);
        repeat (5) step();
        gfix_en = 1'b0;

        // Continuous contention straight after reset: grants alternate every 4 cycles.
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        set_req(0, 1'b0, BASE, 32'h0);
        set_req(1, 1'b0, BASE + 32'd4, 32'h0);
        rearm = 1'b1;
        repeat (16) step();
        rearm = 1'b0;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        repeat (4) step();

        // Unmapped accesses: unused word in the window and outside the window.
        set_req(0, 1'b1, BASE + 32'd8, 32'h7);
        repeat (3) step();
        set_req(0, 1'b0, 32'h0003_0000, 32'h0);
        repeat (3) step();

        // Reset during CAPTURE of a port-0 read, then an immediate port-1 grant.
        set_req(0, 1'b0, BASE, 32'h0);
        step();
        step();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        set_req(1, 1'b0, BASE + 32'd4, 32'h0);
        repeat (5) step();

        // Port 1 request arriving during RESP of a port-0 access.
        set_req(0, 1'b1, BASE, 32'h3);
        repeat (3) step();
        set_req(1, 1'b0, BASE + 32'd4, 32'h0);
        repeat (6) step();

        // Random traffic with occasional resets.
        repeat (1500) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && $urandom_range(0, 2) == 0) rand_req(p);
            end
            rst_drv = ($urandom_range(0, 79) == 0);
            step();
        end
        rst_drv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
